// File: rtl/m68k_bus_arbiter.sv
// 68000 bus-mastership arbiter: hands the bus to Amiga DMA masters via BR/BG/BGACK
// and guarantees the Pi-side cycle engine a minimum tenure between DMA grants.
module m68k_bus_arbiter #(
  parameter int GRANT_TIMEOUT = 16,
  parameter int RECLAIM_DELAY = 2,
  parameter int MIN_OWN       = 4
) (
  input  logic       c200m,
  input  logic       reset,
  input  logic       m68k_clk,
  input  logic       br_n,
  input  logic       bgack_n,
  input  logic       pi_req,
  input  logic       cycle_idle,
  output logic       bus_owned,
  output logic       drive_en,
  output logic       bg_n,
  output logic       dma_active,
  output logic [7:0] grant_count,
  output logic       timeout_flag,
  input  logic       clr_flag
);

  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam int RW = $clog2(RECLAIM_DELAY + 1);
  localparam int HW = $clog2(MIN_OWN + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(GRANT_TIMEOUT - 1);
  localparam logic [RW-1:0] RC_LAST   = RW'(RECLAIM_DELAY - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_OWN);

  typedef enum logic [2:0] {OWN, DRAIN, GRANT, DMA, RECLAIM} state_t;

  state_t        state, state_nxt;
  logic [2:0]    mclk_sync;
  // br/bgack only ever consume stage [1]; the unused third stage is not built.
  logic [1:0]    br_sync, bgack_sync;
  logic          br_s, bgack_s, c7m_fall;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [RW-1:0] rc_cnt, rc_nxt;
  logic          grant_inc, tmo_set;

  always_ff @(posedge c200m or posedge reset) begin
    if (reset) begin
      mclk_sync  <= '0;
      br_sync    <= '1;
      bgack_sync <= '1;
    end else begin
      mclk_sync  <= {mclk_sync[1:0], m68k_clk};
      br_sync    <= {br_sync[0], br_n};
      bgack_sync <= {bgack_sync[0], bgack_n};
    end
  end

  assign br_s     = br_sync[1];
  assign bgack_s  = bgack_sync[1];
  assign c7m_fall = mclk_sync[2] & ~mclk_sync[1];

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    tmo_nxt   = tmo_cnt;
    rc_nxt    = rc_cnt;
    grant_inc = 1'b0;
    tmo_set   = 1'b0;
    if (c7m_fall) begin
      unique case (state)
        OWN: begin
          if (!pi_req)
            hold_nxt = '0;
          else if (hold_cnt != '0)
            hold_nxt = hold_cnt - HW'(1);
          // a dropped pi_req releases the minimum-ownership hold on this same edge
          if (!br_s && (!pi_req || hold_cnt == '0))
            state_nxt = DRAIN;
        end
        DRAIN: begin
          if (br_s) begin
            state_nxt = OWN;
          end else if (cycle_idle) begin
            state_nxt = GRANT;
            tmo_nxt   = '0;
          end
        end
        GRANT: begin
          if (!bgack_s) begin
            state_nxt = DMA;
            grant_inc = 1'b1;
          end else if (br_s) begin
            state_nxt = RECLAIM;
            rc_nxt    = '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state_nxt = RECLAIM;
            rc_nxt    = '0;
            tmo_set   = 1'b1;
          end else begin
            tmo_nxt = tmo_cnt + TW'(1);
          end
        end
        DMA: begin
          if (bgack_s) begin
            state_nxt = RECLAIM;
            rc_nxt    = '0;
          end
        end
        RECLAIM: begin
          if (rc_cnt == RC_LAST) begin
            state_nxt = OWN;
            hold_nxt  = HOLD_INIT;
          end else begin
            rc_nxt = rc_cnt + RW'(1);
          end
        end
        default: state_nxt = OWN;
      endcase
    end
  end

  always_ff @(posedge c200m or posedge reset) begin
    if (reset) begin
      state        <= OWN;
      hold_cnt     <= '0;
      tmo_cnt      <= '0;
      rc_cnt       <= '0;
      bus_owned    <= 1'b1;
      drive_en     <= 1'b1;
      bg_n         <= 1'b1;
      dma_active   <= 1'b0;
      grant_count  <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      tmo_cnt    <= tmo_nxt;
      rc_cnt     <= rc_nxt;
      bus_owned  <= (state_nxt == OWN);
      drive_en   <= (state_nxt == OWN) || (state_nxt == DRAIN);
      bg_n       <= (state_nxt != GRANT);
      dma_active <= (state_nxt == GRANT) || (state_nxt == DMA);
      if (grant_inc)
        grant_count <= grant_count + 8'd1;
      if (tmo_set)
        timeout_flag <= 1'b1;
      else if (clr_flag)
        timeout_flag <= 1'b0;
    end
  end

endmodule
